rom_load_ctrl: RTL
==================

Name: rom_load_ctrl

Overview:
Owns the single-port system ROM BRAM of the PC-8001 core. It shares the BRAM between two requesters: the HPS ROM download stream from the OSD "Load ROM" entry, and CPU instruction/data fetches. While a ROM image is loading, it holds the CPU in reset, then releases it after a fixed settle period. It sits between hps_io's ioctl bus and pc8001m's ROM fetch interface.

Parameters:
ADDR_W, 15, BRAM address width in bytes (32 KiB: 24 KiB main ROM plus 8 KiB expansion ROM).
ROM_INDEX, 8'd1, ioctl_index value that targets this ROM; any other index is ignored.
RST_HOLD, 16, number of clk_sys cycles the CPU reset is held after power-on reset and after each load.

Ports:
clk_sys  in  1  system clock; everything is synchronous to its rising edge.
reset_n  in  1  asynchronous active-low reset.
ioctl_download  in  1  HPS download in progress.
ioctl_index  in  8  download target index.
ioctl_wr  in  1  one-cycle strobe; the byte is valid.
ioctl_addr  in  25  byte address of the download.
ioctl_dout  in  8  download byte.
cpu_req  in  1  CPU read request (level signal; held until cpu_ack).
cpu_addr  in  16  CPU read address.
cpu_ack  out  1  one-cycle pulse; cpu_data is valid in the same cycle.
cpu_data  out  8  read data.
cpu_reset_n  out  1  reset to the CPU (active low).
rom_addr  out  ADDR_W  BRAM address.
rom_din  out  8  BRAM write data.
rom_we  out  1  BRAM write enable.
rom_q  in  8  BRAM read data, registered, 1-cycle latency.
load_len  out  ADDR_W+1  number of bytes accepted in the last load.
load_sum  out  8  modulo-256 sum of the bytes accepted in the last load.
load_ovf  out  1  set if the last load had a write at or above 2^ADDR_W.

Behaviour:
- Reset values: state=BOOT, cpu_reset_n=0, cpu_ack=0, cpu_data=0, rom_we=0, rom_addr=0, rom_din=0, load_len=0, load_sum=0, load_ovf=0, hold counter=0.
- Load qualifier: `active = ioctl_download && ioctl_index==ROM_INDEX`. Other indices have no effect in any state.
- FSM states:
  - BOOT: cpu_reset_n=0; the hold counter increments each cycle; when it reaches RST_HOLD-1, go to RUN. If `active` goes high, go to LOAD.
  - RUN: cpu_reset_n=1; the CPU read port is served. If `active` goes high, go to LOAD on the next edge. If a CPU read is in flight at that point, it is abandoned and no cpu_ack is issued.
  - LOAD: on entry, cpu_reset_n=0 and load_len, load_sum and load_ovf are cleared in the same edge. Every ioctl_wr with ioctl_addr < 2^ADDR_W produces rom_we=1 one cycle later, with rom_addr=ioctl_addr[ADDR_W-1:0] and rom_din=ioctl_dout; load_len increments and load_sum += byte (wraps mod 256). An ioctl_wr with ioctl_addr ≥ 2^ADDR_W sets load_ovf and causes no write. The CPU port is ignored. When `active` falls, go to TAIL and clear the hold counter.
  - TAIL: a write still in flight completes. cpu_reset_n=0 for RST_HOLD cycles, then go to RUN. If `active` rises again, go to LOAD.
- CPU read path (RUN only):
  - Cycle 0: cpu_req is sampled high with no read outstanding; rom_addr is driven with cpu_addr[ADDR_W-1:0].
  - Cycle 1: the BRAM access occurs.
  - Cycle 2: cpu_ack=1 and cpu_data=rom_q (registered).
  - Latency is therefore 2 cycles, with at most one read outstanding.
  - If cpu_addr ≥ 2^ADDR_W, there is no BRAM access; cpu_ack comes at cycle 2 with cpu_data=8'hFF.
  - A new request is accepted the cycle after cpu_ack, so back-to-back throughput is 1 read per 3 cycles.
- Arbitration: the loader has absolute priority. rom_we is never asserted in RUN or BOOT. A write in flight when the state changes still completes.
- rom_we is exactly one cycle per accepted ioctl_wr. Two ioctl_wr strobes on consecutive cycles produce two consecutive write cycles; no byte is dropped.
- load_len saturates at 2^ADDR_W.
- Async reset mid-load aborts everything: BRAM contents are undefined, and the FSM returns to BOOT.

Test Plan:
1. Deassert reset_n and keep cpu_req=0 → cpu_reset_n stays 0 for exactly 16 cycles, then goes to 1; all other outputs stay at their reset values.
2. In RUN, preload BRAM[0x0123]=0xA5 and issue cpu_req with cpu_addr=0x0123 → cpu_ack pulses 2 cycles later with cpu_data=0xA5; hold cpu_req and check the next ack arrives 3 cycles after the first. Issue cpu_addr=0x9000 → cpu_data=0xFF.
3. Run a download with index 1 of 4 bytes 0x01,0x02,0x03,0xFF at addr 0–3 with back-to-back ioctl_wr → 4 consecutive rom_we cycles; load_len=4, load_sum=0x05, load_ovf=0; cpu_reset_n=0 throughout, then 1 exactly 16 cycles after ioctl_download falls.
4. Run a download with index 1 and a write at ioctl_addr=0x8000 → no rom_we; load_ovf=1; load_len unchanged.
5. Run a download with index 2 during RUN → no rom_we; cpu_reset_n stays 1; CPU reads continue unaffected.
6. Start a download while a CPU read is at cycle 1 → no cpu_ack; LOAD entered the next edge. Assert reset_n=0 mid-load → state returns to BOOT and all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/rom_load_ctrl.sv
`timescale 1ns/1ps
// rom_load_ctrl: owns the single-port system ROM BRAM and arbitrates it
// between the HPS ROM download stream (absolute priority) and CPU fetches.
// Holds the CPU in reset during boot and while a ROM image loads, then
// releases it after RST_HOLD cycles.
//
// Ports:
//   clk_sys, reset_n            clock, async active-low reset
//   ioctl_download/index/wr/    hps_io download bus (byte stream)
//   ioctl_addr/ioctl_dout
//   cpu_req/cpu_addr            CPU read request (level, held until ack)
//   cpu_ack/cpu_data            one-cycle ack with read data (0xFF off-ROM)
//   cpu_reset_n                 active-low reset to the CPU
//   rom_addr/rom_din/rom_we     BRAM port
//   rom_q                       BRAM registered read data (1-cycle latency)
//   load_len/load_sum/load_ovf  statistics of the last load
module rom_load_ctrl #(
    parameter int unsigned ADDR_W    = 15,
    parameter logic [7:0]  ROM_INDEX = 8'd1,
    parameter int unsigned RST_HOLD  = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              cpu_req,
    input  logic [15:0]       cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_data,
    output logic              cpu_reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_din,
    output logic              rom_we,
    input  logic [7:0]        rom_q,
    output logic [ADDR_W:0]   load_len,
    output logic [7:0]        load_sum,
    output logic              load_ovf
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2,
        ST_TAIL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cpu_reset_n_q, cpu_reset_n_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [7:0]          cpu_data_q, cpu_data_d;
    logic                rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]          rom_din_q, rom_din_d;
    logic [LEN_W-1:0]    load_len_q, load_len_d;
    logic [7:0]          load_sum_q, load_sum_d;
    logic                load_ovf_q, load_ovf_d;
    logic                rd1_q, rd1_d, rd1_oob_q, rd1_oob_d;
    logic                rd2_q, rd2_d, rd2_oob_q, rd2_oob_d;

    logic active_c, hold_done_c, wr_in_range_c, rd_in_range_c;
    logic wr_acc_c, run_stay_c, load_entry_c;

    assign active_c      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign hold_done_c   = (hold_q == HOLD_W'(RST_HOLD - 1));
    assign wr_in_range_c = ~|ioctl_addr[24:ADDR_W];
    assign rd_in_range_c = ~|cpu_addr[15:ADDR_W];
    assign wr_acc_c      = (state_q == ST_LOAD) && active_c && ioctl_wr;
    // Reads only progress while RUN persists; leaving RUN abandons them.
    assign run_stay_c    = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign load_entry_c  = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= ST_BOOT;
        else          state_q <= state_d;
    end

    // Next-state logic; a load request always wins
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT, ST_TAIL: begin
                if (active_c)         state_d = ST_LOAD;
                else if (hold_done_c) state_d = ST_RUN;
            end
            ST_RUN:  if (active_c)  state_d = ST_LOAD;
            ST_LOAD: if (!active_c) state_d = ST_TAIL;
            default: state_d = ST_BOOT;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        hold_d        = '0;
        cpu_reset_n_d = (state_d == ST_RUN);
        cpu_ack_d     = 1'b0;
        cpu_data_d    = cpu_data_q;
        rom_we_d      = 1'b0;
        rom_addr_d    = rom_addr_q;
        rom_din_d     = rom_din_q;
        load_len_d    = load_len_q;
        load_sum_d    = load_sum_q;
        load_ovf_d    = load_ovf_q;
        rd1_d         = 1'b0;
        rd1_oob_d     = rd1_oob_q;
        rd2_d         = 1'b0;
        rd2_oob_d     = rd2_oob_q;

        // Hold counter runs only while staying in BOOT or TAIL
        if (((state_q == ST_BOOT) || (state_q == ST_TAIL)) && (state_d == state_q)) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        // Loader: statistics restart on each LOAD entry
        if (load_entry_c) begin
            load_len_d = '0;
            load_sum_d = '0;
            load_ovf_d = 1'b0;
        end else if (wr_acc_c) begin
            if (wr_in_range_c) begin
                rom_we_d   = 1'b1;
                rom_addr_d = ioctl_addr[ADDR_W-1:0];
                rom_din_d  = ioctl_dout;
                load_sum_d = load_sum_q + ioctl_dout;
                if (load_len_q != LEN_MAX) load_len_d = load_len_q + LEN_W'(1);
            end else begin
                load_ovf_d = 1'b1;
            end
        end

        // CPU read pipeline: accept -> BRAM access -> ack
        if (run_stay_c) begin
            rd2_d     = rd1_q;
            rd2_oob_d = rd1_oob_q;
            if (rd2_q) begin
                cpu_ack_d  = 1'b1;
                cpu_data_d = rd2_oob_q ? 8'hFF : rom_q;
            end
            if (cpu_req && !rd1_q && !rd2_q) begin
                rd1_d     = 1'b1;
                rd1_oob_d = !rd_in_range_c;
                if (rd_in_range_c) rom_addr_d = cpu_addr[ADDR_W-1:0];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_q        <= '0;
            cpu_reset_n_q <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cpu_data_q    <= '0;
            rom_we_q      <= 1'b0;
            rom_addr_q    <= '0;
            rom_din_q     <= '0;
            load_len_q    <= '0;
            load_sum_q    <= '0;
            load_ovf_q    <= 1'b0;
            rd1_q         <= 1'b0;
            rd1_oob_q     <= 1'b0;
            rd2_q         <= 1'b0;
            rd2_oob_q     <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_data_q    <= cpu_data_d;
            rom_we_q      <= rom_we_d;
            rom_addr_q    <= rom_addr_d;
            rom_din_q     <= rom_din_d;
            load_len_q    <= load_len_d;
            load_sum_q    <= load_sum_d;
            load_ovf_q    <= load_ovf_d;
            rd1_q         <= rd1_d;
            rd1_oob_q     <= rd1_oob_d;
            rd2_q         <= rd2_d;
            rd2_oob_q     <= rd2_oob_d;
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign cpu_data    = cpu_data_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign rom_we      = rom_we_q;
    assign rom_addr    = rom_addr_q;
    assign rom_din     = rom_din_q;
    assign load_len    = load_len_q;
    assign load_sum    = load_sum_q;
    assign load_ovf    = load_ovf_q;

endmodule
